// File: rtl/vig_pkg.sv
// Shared Vigenere types and byte arithmetic for the encryptor/decryptor pair.
package vig_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        KEY_WAIT = 2'd0,
        RUN      = 2'd1,
        DRAIN    = 2'd2
    } dec_state_e;

    // Encrypt one byte: modulo-256 add.
    function automatic byte_t vig_add(input byte_t p, input byte_t k);
        return byte_t'(p + k);
    endfunction

    // Decrypt one byte: modulo-256 subtract.
    function automatic byte_t vig_sub(input byte_t c, input byte_t k);
        return byte_t'(c - k);
    endfunction

endpackage

// File: rtl/decryptor_stream_key_store.sv
// Key register file with range-checked write port and a rolling key index.
module key_store
    import vig_pkg::*;
#(
    parameter int unsigned SEC_LEN = 3,
    parameter int unsigned KA_W    = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en_i,
    input  logic            wr_allow_i,
    input  logic [KA_W-1:0] wr_addr_i,
    input  byte_t           wr_data_i,
    input  logic            advance_i,
    input  logic            restart_i,
    output byte_t           rd_data_o,
    output logic            wr_err_o
);

    byte_t           key_q [SEC_LEN];
    logic [KA_W-1:0] idx_q;
    logic [KA_W-1:0] idx_d;
    logic            wr_err_q;
    logic            addr_ok_c;
    logic            wr_hit_c;
    logic            idx_end_c;

    // Address range check; write lands only when the owner allows it.
    always_comb begin
        addr_ok_c = (32'(wr_addr_i) < SEC_LEN);
        wr_hit_c  = wr_en_i && wr_allow_i && addr_ok_c;
        idx_end_c = (32'(idx_q) == SEC_LEN - 1);
    end

    // Key byte storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SEC_LEN); i++) begin
                key_q[i] <= '0;
            end
        end else if (wr_hit_c) begin
            key_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Rejected-write pulse: out-of-range address or write while locked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_en_i && !(wr_allow_i && addr_ok_c);
        end
    end

    // Next key index: restart wins, otherwise advance with wrap.
    always_comb begin
        idx_d = idx_q;
        if (restart_i) begin
            idx_d = '0;
        end else if (advance_i) begin
            idx_d = idx_end_c ? '0 : KA_W'(idx_q + 1'b1);
        end
    end

    // Key index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign rd_data_o = key_q[idx_q];
    assign wr_err_o  = wr_err_q;

endmodule

// File: rtl/decryptor_stream.sv
// Streaming Vigenere decryptor: p = c - key[i], one byte per cycle.
module decryptor_stream
    import vig_pkg::*;
#(
    parameter  int unsigned SEC_LEN = 3,
    parameter  int unsigned CNT_W   = 16,
    localparam int unsigned KA_W    = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_wr_en,
    input  logic [KA_W-1:0]  key_wr_addr,
    input  logic [7:0]       key_wr_data,
    input  logic             key_commit,
    input  logic             key_clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             msg_done,
    output logic             key_wr_err,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             armed
);

    dec_state_e        state_q;
    dec_state_e        state_d;

    logic              out_valid_q;
    byte_t             out_data_q;
    logic              out_last_q;
    logic              msg_done_q;
    logic [CNT_W-1:0]  byte_cnt_q;

    logic              in_ready_c;
    logic              in_xfer_c;
    logic              out_xfer_c;
    logic              ks_restart_c;
    logic              ks_wr_allow_c;
    byte_t             key_byte;

    key_store #(
        .SEC_LEN (SEC_LEN),
        .KA_W    (KA_W)
    ) u_key_store (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (key_wr_en),
        .wr_allow_i (ks_wr_allow_c),
        .wr_addr_i  (key_wr_addr),
        .wr_data_i  (key_wr_data),
        .advance_i  (in_xfer_c),
        .restart_i  (ks_restart_c),
        .rd_data_o  (key_byte),
        .wr_err_o   (key_wr_err)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= KEY_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: load key, run, then drain the output register.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            KEY_WAIT: if (key_commit) state_d = RUN;
            RUN:      if (key_clear)  state_d = DRAIN;
            DRAIN:    if (!out_valid_q || out_xfer_c) state_d = KEY_WAIT;
            default:  state_d = KEY_WAIT;
        endcase
    end

    // FSM outputs: handshake, key-store controls.
    always_comb begin
        in_ready_c    = 1'b0;
        ks_wr_allow_c = 1'b0;
        ks_restart_c  = 1'b1;
        out_xfer_c    = out_valid_q && out_ready;
        unique case (state_q)
            KEY_WAIT: ks_wr_allow_c = 1'b1;
            RUN: begin
                in_ready_c   = !out_valid_q || out_ready;
                ks_restart_c = in_valid && in_ready_c && in_last;
            end
            default: ;
        endcase
        in_xfer_c = in_valid && in_ready_c;
    end

    // Single-entry output register; holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (in_xfer_c) begin
            out_valid_q <= 1'b1;
            out_data_q  <= vig_sub(byte_t'(in_data), key_byte);
            out_last_q  <= in_last;
        end else if (out_xfer_c) begin
            out_valid_q <= 1'b0;
        end
    end

    // Delivered-byte counter and end-of-message pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_done_q <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            msg_done_q <= out_xfer_c && out_last_q;
            if (out_xfer_c) begin
                byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign msg_done  = msg_done_q;
    assign byte_cnt  = byte_cnt_q;
    assign armed     = (state_q == RUN);

endmodule

// File: tb/tb_decryptor_stream.sv
// Scoreboard bench for decryptor_stream with key "KEY" and directed vectors.
module tb_decryptor_stream;

    logic        clk;
    logic        rst;
    logic        key_wr_en;
    logic [1:0]  key_wr_addr;
    logic [7:0]  key_wr_data;
    logic        key_commit;
    logic        key_clear;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        msg_done;
    logic        key_wr_err;
    logic [15:0] byte_cnt;
    logic        armed;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   errors;
    int   checks;
    int   delivered;
    int   cyc;

    decryptor_stream #(.SEC_LEN(3), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_wr_en   (key_wr_en),
        .key_wr_addr (key_wr_addr),
        .key_wr_data (key_wr_data),
        .key_commit  (key_commit),
        .key_clear   (key_clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .msg_done    (msg_done),
        .key_wr_err  (key_wr_err),
        .byte_cnt    (byte_cnt),
        .armed       (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
        logic [7:0] k [3];
        k[0] = k0; k[1] = k1; k[2] = k2;
        for (int i = 0; i < 3; i++) begin
            key_wr_en   = 1'b1;
            key_wr_addr = 2'(i);
            key_wr_data = k[i];
            tick();
        end
        key_wr_en  = 1'b0;
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
    endtask

    // Present one byte, push its expected plaintext when the handshake is seen.
    task automatic send(input logic [7:0] d, input logic last, input logic [7:0] exp);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({exp, last});
                done = 1'b1;
            end
        end
        if (!done) chk("send_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: compare every output transfer against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                delivered++;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_output", 32'(out_data), 32'(999));
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_last", 32'(out_last), 32'(e.last));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        errors = 0; checks = 0; delivered = 0; cyc = 0;
        rst = 1'b1;
        key_wr_en = 1'b0; key_wr_addr = '0; key_wr_data = '0;
        key_commit = 1'b0; key_clear = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_armed", 32'(armed), 32'(0));
        chk("rst_byte_cnt", 32'(byte_cnt), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Key "KEY", single byte 147 -> 'H'
        load_key(8'd75, 8'd69, 8'd89);
        chk("armed_after_commit", 32'(armed), 32'(1));
        send(8'd147, 1'b1, 8'd72);
        tick();
        chk("msg_done_pulse", 32'(msg_done), 32'(1));
        chk("byte_cnt_one", 32'(byte_cnt), 32'(1));
        tick();
        chk("msg_done_low", 32'(msg_done), 32'(0));

        // "HELLO" at one byte per cycle
        t0 = cyc;
        send(8'd147, 1'b0, 8'd72);
        send(8'd138, 1'b0, 8'd69);
        send(8'd165, 1'b0, 8'd76);
        send(8'd151, 1'b0, 8'd76);
        send(8'd148, 1'b1, 8'd79);
        chk("hello_cycles", 32'(cyc - t0), 32'(5));

        // Modular underflow and key restart after last
        send(8'd10, 1'b1, 8'd191);
        send(8'd147, 1'b1, 8'd72);
        send(8'd140, 1'b1, 8'd65);
        tick();

        // Backpressure: output stalls, input must not be accepted
        out_ready = 1'b0;
        send(8'd147, 1'b0, 8'd72);
        in_valid = 1'b1; in_data = 8'd138; in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'(0));
            chk("bp_out_data", 32'(out_data), 32'(72));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'd138, 1'b0, 8'd69);
        send(8'd165, 1'b1, 8'd76);
        tick();

        // Key write in RUN is rejected and leaves the key intact
        key_wr_en = 1'b1; key_wr_addr = 2'd0; key_wr_data = 8'd0;
        tick();
        key_wr_en = 1'b0;
        chk("run_wr_err", 32'(key_wr_err), 32'(1));
        tick();
        chk("run_wr_err_low", 32'(key_wr_err), 32'(0));
        send(8'd147, 1'b1, 8'd72);
        tick();
        chk("byte_cnt_total", 32'(byte_cnt), 32'(delivered));

        // Clear with a byte pending: byte still delivered
        out_ready = 1'b0;
        send(8'd147, 1'b1, 8'd72);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        chk("drain_armed", 32'(armed), 32'(0));
        chk("drain_in_ready", 32'(in_ready), 32'(0));
        chk("drain_pending", 32'(out_valid), 32'(1));
        out_ready = 1'b1;
        tick();
        chk("drained_valid", 32'(out_valid), 32'(0));
        chk("drained_armed", 32'(armed), 32'(0));
        chk("drained_sb_empty", 32'(sb.size()), 32'(0));

        // Out-of-range key address in KEY_WAIT
        key_wr_en = 1'b1; key_wr_addr = 2'd3; key_wr_data = 8'd1;
        tick();
        key_wr_en = 1'b0;
        chk("addr3_wr_err", 32'(key_wr_err), 32'(1));

        // Commit alone re-arms with the retained key
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
        chk("rearm", 32'(armed), 32'(1));
        send(8'd147, 1'b1, 8'd72);

        // Write and commit in the same cycle: new key byte applies
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        tick();
        key_wr_en = 1'b1; key_wr_addr = 2'd0; key_wr_data = 8'd0; key_commit = 1'b1;
        tick();
        key_wr_en = 1'b0; key_commit = 1'b0;
        send(8'd147, 1'b1, 8'd147);
        tick();

        // Async reset mid-message
        out_ready = 1'b0;
        send(8'd50, 1'b0, 8'd50);
        rst = 1'b1;
        #2;
        sb.delete();
        chk("arst_out_valid", 32'(out_valid), 32'(0));
        chk("arst_out_data", 32'(out_data), 32'(0));
        chk("arst_out_last", 32'(out_last), 32'(0));
        chk("arst_byte_cnt", 32'(byte_cnt), 32'(0));
        chk("arst_armed", 32'(armed), 32'(0));
        chk("arst_in_ready", 32'(in_ready), 32'(0));
        chk("arst_msg_done", 32'(msg_done), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // Key cleared by reset: commit with zero key passes bytes through
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
        send(8'd5, 1'b1, 8'd5);
        for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
        chk("final_sb_empty", 32'(sb.size()), 32'(0));
        chk("final_byte_cnt", 32'(byte_cnt), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
